branch_predict_ctrl: RTL
========================

# branch_predict_ctrl

Branch prediction and misprediction-recovery controller for the pipelined RV32I core. It holds a bimodal table of 2-bit saturating counters that the fetch stage reads to predict conditional branches. The EX stage trains the table with the resolved outcome from `taken_branch`. On a misprediction it issues a one-cycle registered flush plus a redirect PC to fetch.

## Interface
- `IDX_BITS`, 6: table index width; table depth = 2^IDX_BITS entries; index = pc[IDX_BITS+1:2].
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `f_pc` in 32: PC of the instruction being fetched.
- `f_pred_taken` out 1: combinational; MSB of the counter at index(`f_pc`).
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_is_branch` in 1: EX instruction is B-type (opcode 7'b1100011).
- `ex_stall` in 1: EX held this cycle; no training, no flush.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_pred_taken` in 1: prediction carried down the pipe with the instruction.
- `ex_taken` in 1: resolved outcome from `taken_branch`.
- `ex_target` in 32: branch target (pc + B-imm).
- `flush` out 1: registered; kills IF/ID/EX wrong-path instructions.
- `redirect_pc` out 32: registered; valid when `flush` = 1.
- `br_count` out 32: resolved-branch count (only with `BRANCH_STATS_EN`).
- `mispred_count` out 32: misprediction count (only with `BRANCH_STATS_EN`).

## Operation
- A resolve event occurs when `ex_valid & ex_is_branch & !ex_stall & !flush`.
- During the cycle `flush` = 1, the EX instruction is wrong-path. All EX inputs are ignored.
- On a resolve event, counter[index(`ex_pc`)] is updated:
  - `ex_taken` = 1: increment, saturating at 2'b11.
  - `ex_taken` = 0: decrement, saturating at 2'b00.
- A mispredict is a resolve event with `ex_pred_taken != ex_taken`.
- On a mispredict, the next cycle has `flush` = 1 and `redirect_pc` set as follows:
  - `ex_taken` = 1: `ex_target`.
  - `ex_taken` = 0: `ex_pc + 4`, with 32-bit wrap.
- `flush` is a single-cycle pulse. A correct prediction produces no flush.
- The controller has two states:
  - IDLE: `flush` = 0. A mispredict moves it to FLUSH.
  - FLUSH: `flush` = 1. It returns to IDLE unconditionally.
  - A mispredict cannot occur in FLUSH, because EX inputs are ignored there.
- Aliasing is permitted. PCs with equal index bits share a counter; there are no tags.
- If a read and an update hit the same index in the same cycle, `f_pred_taken` shows the pre-update value (no bypass).
- Non-branch or invalid EX instructions never touch the table.

## Timing
- Prediction has 0-cycle latency: combinational from `f_pc` through the register array.
- A table update is visible to fetch on the cycle after the resolve edge.
- Flush/redirect latency is 1 cycle after the resolve cycle. Fetch drives `redirect_pc` on that same cycle.
- Reset values:
  - All counters = 2'b01 (weakly not-taken).
  - `flush` = 0, `redirect_pc` = 32'h0, state = IDLE.
  - `br_count` = `mispred_count` = 0.
- Asserting `rst_n` low mid-flush clears `flush` immediately. The pending redirect is dropped.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `br_count` increments on every resolve event.
  - `mispred_count` increments on every mispredict.
  - Both are 32-bit and wrap from 32'hFFFFFFFF to 0.
- `BRANCH_STATS_EN` undefined: both ports and their counters are absent. The prediction and flush behaviour is identical.

## Structure
- `branch_pkg` holds:
  - The counter encoding: SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11.
  - The `OPC_BRANCH` = 7'b1100011 constant.
  - The controller state enum (IDLE, FLUSH).
- Sub-module `sat_counter2` implements the next-state function of the 2-bit saturating counter (inc/dec, clamp). It is instantiated once and applied to the indexed entry.
- The table is a flop array, not BRAM, because the read must be asynchronous and reset must cover every entry.

## Test plan
- Reset, then `f_pc` = 0x100 -> `f_pred_taken` = 0. Every index reads 2'b01.
- Resolve at `ex_pc` = 0x100, pred = 0, taken = 1, `ex_target` = 0x10C -> next cycle `flush` = 1 and `redirect_pc` = 0x10C. After that, `f_pc` = 0x100 predicts 1.
- Three further taken resolves at 0x100 with pred = 1 -> no flush, counter saturates at 11. One not-taken resolve -> counter = 10, `flush` = 1, `redirect_pc` = 0x104.
- Aliasing: train 0x200 taken (same index as 0x100 with `IDX_BITS` = 6) -> the prediction for 0x100 changes accordingly. A same-cycle read/update returns the old value.
- Mispredict followed immediately by a valid mispredicting branch in EX during the flush cycle -> only one flush pulse, no table update for the second branch. `ex_stall` = 1 with a mispredict -> no flush, no update.
- With `BRANCH_STATS_EN`: 5 resolves including 2 mispredicts -> `br_count` = 5, `mispred_count` = 2. Asserting `rst_n` low during `flush` -> `flush` = 0 at once and both counts return to 0.

Source files
------------

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the branch prediction controller:
// counter encoding, B-type opcode and controller state enum.
package branch_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // Decode helper for stages that derive ex_is_branch from the raw opcode.
   function automatic logic is_branch_opcode(input logic [6:0] opc);
      return opc == OPC_BRANCH;
   endfunction

endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// Next-state function of a 2-bit saturating counter: increment on taken,
// decrement on not-taken, clamped at ST and SNT.
module sat_counter2
   import branch_pkg::*;
(
   input  ctr_t cur,
   input  logic taken,
   output ctr_t nxt
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != ST) nxt = ctr_t'(cur + 2'd1);
      end else begin
         if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
      end
   end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor with misprediction flush/redirect.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_predict_ctrl
   import branch_pkg::*;
#(
   parameter int IDX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] f_pc,
   output logic        f_pred_taken,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_stall,
   input  logic [31:0] ex_pc,
   input  logic        ex_pred_taken,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   output logic        flush,
`ifdef BRANCH_STATS_EN
   output logic [31:0] br_count,
   output logic [31:0] mispred_count,
`endif
   output logic [31:0] redirect_pc
);

   localparam int DEPTH = 1 << IDX_BITS;

   ctr_t                pht_q [DEPTH];
   ctr_t                ctr_nxt;
   logic [IDX_BITS-1:0] f_idx;
   logic [IDX_BITS-1:0] ex_idx;
   logic                resolve;
   logic                mispredict;
   state_t              state_q;
   state_t              state_d;
   logic [31:0]         redirect_q;
   logic                unused_f_pc_bits;

   assign f_idx            = f_pc[IDX_BITS+1:2];
   assign ex_idx           = ex_pc[IDX_BITS+1:2];
   assign unused_f_pc_bits = ^{f_pc[31:IDX_BITS+2], f_pc[1:0]};

   // Read is asynchronous and unbypassed: a same-cycle update shows next cycle.
   assign f_pred_taken = pht_q[f_idx][1];

   // EX contents are wrong-path while flush is high, so nothing resolves then.
   assign resolve    = ex_valid & ex_is_branch & ~ex_stall & (state_q == IDLE);
   assign mispredict = resolve & (ex_pred_taken != ex_taken);

   sat_counter2 u_sat (
      .cur   (pht_q[ex_idx]),
      .taken (ex_taken),
      .nxt   (ctr_nxt)
   );

   // NOTE: the table is a flop array with every entry reset, not a RAM, so it
   // starts at weakly-not-taken and can be read combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pht_q[i] <= WNT;
      end else if (resolve) begin
         pht_q[ex_idx] <= ctr_nxt;
      end
   end

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mispredict) state_d = FLUSH;
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_q <= 32'h0;
      end else if (mispredict) begin
         redirect_q <= ex_taken ? ex_target : ex_pc + 32'd4;
      end
   end

   assign flush       = (state_q == FLUSH);
   assign redirect_pc = redirect_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] br_q;
   logic [31:0] mispred_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_q      <= 32'h0;
         mispred_q <= 32'h0;
      end else begin
         if (resolve)    br_q      <= br_q + 32'd1;
         if (mispredict) mispred_q <= mispred_q + 32'd1;
      end
   end

   assign br_count      = br_q;
   assign mispred_count = mispred_q;
`endif

endmodule
